// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shift_add_dp.sv
// Shift-and-add datapath: operand capture, accumulator and bit counter.
// One partial product is added per step; o_acc_nxt includes the current step's add.
module shift_add_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_acc_nxt,
    output logic                 o_last
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] w_addend;

    assign w_addend  = r_b[r_cnt] ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0;
    assign o_acc_nxt = r_acc + w_addend;
    assign o_last    = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= o_acc_nxt;
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for a WIDTH x WIDTH shift-and-add multiplier with start/busy and done/ack handshakes.
// Fixed WIDTH-cycle latency; product is held until the next completion.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 ack,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    mult_state_t        r_state;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_product;
    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic [2*WIDTH-1:0] w_acc_nxt;

    // DONE+ack+start restarts directly, skipping IDLE
    assign w_accept = start && ((r_state == IDLE) || ((r_state == DONE) && ack));
    assign w_step   = (r_state == RUN);

    shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_load    (w_accept),
        .i_step    (w_step),
        .i_a       (a),
        .i_b       (b),
        .o_acc_nxt (w_acc_nxt),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_product <= w_acc_nxt;
                    end
                end
                DONE: begin
                    if (ack) begin
                        r_done <= 1'b0;
                        if (w_accept) begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl at WIDTH=4 plus a WIDTH=8 regression instance.
module tb_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  a = '0;
    logic [3:0]  b = '0;
    logic        ack = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  product;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        ack8 = 1'b0;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ack(ack),
        .busy(busy), .done(done), .product(product)
    );

    mult_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .ack(ack8),
        .busy(busy8), .done(done8), .product(product8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with exact latency checks, then ack back to IDLE.
    task automatic mul_fixed(input string tag, input logic [3:0] x, input logic [3:0] y,
                             input logic [7:0] exp);
        a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_t0"}, 32'(busy), 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk({tag, "_busy_run"}, 32'(busy), 32'd1);
        end
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        chk({tag, "_prod"}, 32'(product), 32'(exp));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk({tag, "_idle"}, 32'(done), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_prod", 32'(product), 32'd0);
        chk("rst_prod8", 32'(product8), 32'd0);
        reset = 1'b0;
        tick();

        // 3*5 with hold and ack
        a = 4'd3; b = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("m35_busy_t0", 32'(busy), 32'd1);
        chk("m35_done_t0", 32'(done), 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("m35_busy_run", 32'(busy), 32'd1);
            chk("m35_prod_run", 32'(product), 32'd0);
        end
        tick();
        chk("m35_done", 32'(done), 32'd1);
        chk("m35_busy_off", 32'(busy), 32'd0);
        chk("m35_prod", 32'(product), 32'h0F);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("m35_hold_done", 32'(done), 32'd1);
            chk("m35_hold_prod", 32'(product), 32'h0F);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("m35_ack_done", 32'(done), 32'd0);
        chk("m35_ack_busy", 32'(busy), 32'd0);
        chk("m35_ack_prod", 32'(product), 32'h0F);

        mul_fixed("m15x15", 4'd15, 4'd15, 8'hE1);
        mul_fixed("m0x9", 4'd0, 4'd9, 8'h00);

        // exhaustive sweep against a*b
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                int k;
                a = 4'(i); b = 4'(j); start = 1'b1;
                tick();
                start = 1'b0;
                k = 0;
                while (!done && k < 20) begin
                    tick();
                    k++;
                end
                if (!done) chk("sweep_timeout", 32'(done), 32'd1);
                else chk("sweep_prod", 32'(product), 32'(i * j));
                ack = 1'b1;
                tick();
                ack = 1'b0;
            end
        end

        // 6*7 while start/a/b wiggle during RUN
        a = 4'd6; b = 4'd7; start = 1'b1;
        tick();
        a = 4'd2; b = 4'd2;
        chk("ign_busy_t0", 32'(busy), 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            a = ~a; b = b ^ 4'd3;
            chk("ign_busy_run", 32'(busy), 32'd1);
        end
        tick();
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_prod", 32'(product), 32'h2A);
        // start without ack in DONE is ignored
        a = 4'd1; b = 4'd1;
        tick();
        chk("nack_done", 32'(done), 32'd1);
        chk("nack_busy", 32'(busy), 32'd0);
        chk("nack_prod", 32'(product), 32'h2A);

        // back-to-back restart from DONE
        a = 4'd9; b = 4'd9; ack = 1'b1; start = 1'b1;
        tick();
        ack = 1'b0; start = 1'b0;
        chk("b2b_done_drop", 32'(done), 32'd0);
        chk("b2b_busy_rise", 32'(busy), 32'd1);
        chk("b2b_prod_held", 32'(product), 32'h2A);
        for (int i = 1; i < 4; i++) tick();
        chk("b2b_busy_last", 32'(busy), 32'd1);
        tick();
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_prod", 32'(product), 32'h51);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // async reset mid-RUN at cnt=2
        a = 4'd7; b = 4'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_prod", 32'(product), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        mul_fixed("m4x4", 4'd4, 4'd4, 8'h10);

        // WIDTH=8 corner
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("w8_busy_t0", 32'(busy8), 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("w8_busy_run", 32'(busy8), 32'd1);
        end
        tick();
        chk("w8_done", 32'(done8), 32'd1);
        chk("w8_prod", 32'(product8), 32'hFE01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequencer for a shift-and-add 4x4 unsigned multiplier, replacing the purely combinational multiply path when area matters.
- Accepts an operand pair through a start/busy handshake and runs one partial product per clock.
- Presents a registered 2*WIDTH product with a held done flag until acknowledged.
- Sits between the switch/operand registers and the hex-decoder display stage; the product splits into nibbles for display as before.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH; legal range 2..8.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request to multiply a*b; sampled only in IDLE or DONE.
a  input  WIDTH  multiplicand, unsigned; captured on accepted start.
b  input  WIDTH  multiplier, unsigned; captured on accepted start.
ack  input  1  consumer acknowledges result; meaningful only in DONE.
busy  output  1  high while in RUN.
done  output  1  high while in DONE; result valid.
product  output  2*WIDTH  last completed result; held until the next completion.

Behaviour:
- Clocking:
  - One clock.
  - Reset is asynchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, product=0, internal a_reg/b_reg/acc/cnt=0.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- Accept:
  - Occurs at a rising edge where start=1 and state is IDLE, or state is DONE with ack=1.
  - Effect: a_reg<=a, b_reg<=b, acc<=0, cnt<=0, state<=RUN.
- RUN, each cycle:
  - If b_reg[cnt]=1: acc <= acc + (zero-extended a_reg << cnt), computed at 2*WIDTH bits. No overflow is possible.
  - cnt <= cnt+1.
  - When cnt=WIDTH-1: product <= final acc (including this cycle's add), state<=DONE.
- Latency:
  - Accept edge at T0: busy=1 from T0 to T0+WIDTH.
  - done=1 and product valid from edge T0+WIDTH onward (WIDTH RUN cycles).
  - Fixed latency; no early exit on b_reg=0.
- DONE:
  - Holds done=1 and product until ack=1.
  - ack=1 with start=0: IDLE at next edge, done drops.
  - ack=1 with start=1: counts as accept; go straight to RUN with the new operands (back-to-back, no IDLE bubble). done drops and busy rises on the same edge.
  - start=1 with ack=0: ignored; the result is not overwritten.
- Ignored inputs:
  - start in RUN is ignored; a/b changes in RUN have no effect.
  - ack outside DONE is ignored.
- product register changes only on the RUN->DONE edge and on reset. During RUN it shows the previous result.
- Reset mid-RUN: immediate return to IDLE, product=0, partial result discarded.
- Illegal state encodings: next state IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package mult_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t
  - localparam DEFAULT_WIDTH=4
  - function cnt_width(WIDTH) = $clog2(WIDTH)
- Sub-module shift_add_dp:
  - Holds a_reg, b_reg, acc and cnt.
  - Inputs from the FSM: load, step.
  - Output to the FSM: last (cnt==WIDTH-1).
  - mult_seq_ctrl keeps the FSM and the product/done/busy registers.

Test Plan:
- Reset, then start with a=3, b=5 at edge T0: busy=1 for 4 cycles; done=1 and product=8'h0F at edge T0+4; held for 3 cycles without ack; ack pulse leads to IDLE, done=0, product still 8'h0F.
- a=15, b=15: product=8'hE1 (225). Then a=0, b=9: product=8'h00 with the same 4-cycle latency. Sweep all 256 pairs against a reference model.
- During RUN of 6*7, drive start=1 with a=2, b=2 and toggle a/b: product=8'h2A (42), no restart, busy stays 4 cycles.
- In DONE with product=8'h2A, assert start=1, ack=1 with a=9, b=9: next edge done=0, busy=1; 4 edges later product=8'h51 (81). With ack=0 and start=1 in DONE, product stays unchanged.
- Assert reset asynchronously mid-RUN (between edges, cnt=2): outputs go to zero immediately. After release, start with a=4, b=4 gives product=8'h10 with normal latency.
- Regression at WIDTH=8: a=255, b=255 gives product=16'hFE01 after 8 RUN cycles.
